// File: rtl/wb_stage_if.sv
// Writeback-stage bus: memory-stage inputs and the writeback-side outputs.
// The slave modport is the writeback stage; the master modport is whatever
// drives the memory-stage side and observes the register-file write port.
interface wb_stage_if;
  logic [8:0]  control_word_mem;   // {rf_wb, wb_src[1:0], pc_src, rd[4:0]}
  logic [31:0] ALU_result_mem;
  logic [31:0] memory_stage_data;
  logic [31:0] pc_plus4_mem;
  logic [31:0] target_pc;
  logic        valid_mem;
  logic        mem_rdy;
  logic        flush;
  logic        stall_mem;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pc_redirect;
  logic [31:0] pc_redirect_target;
  logic        wb_valid;
  logic        load_err;
  logic [31:0] instret;

  modport slave (
    input  control_word_mem, ALU_result_mem, memory_stage_data, pc_plus4_mem,
           target_pc, valid_mem, mem_rdy, flush,
    output stall_mem, rf_we, rf_waddr, rf_wdata, pc_redirect,
           pc_redirect_target, wb_valid, load_err, instret
  );

  modport master (
    output control_word_mem, ALU_result_mem, memory_stage_data, pc_plus4_mem,
           target_pc, valid_mem, mem_rdy, flush,
    input  stall_mem, rf_we, rf_waddr, rf_wdata, pc_redirect,
           pc_redirect_target, wb_valid, load_err, instret
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: selects the writeback value, drives the register-file
// write port and a one-cycle fetch redirect, stalls upstream while load data
// is outstanding and flags loads that wait too long (sticky load_err).
// Optional feature macro: WB_INSTRET_EN enables the 32-bit retired-instruction
// counter; without it instret is tied to zero.
module wb_stage #(
  parameter int unsigned LOAD_TIMEOUT = 8   // 1..255
) (
  input  logic       clk,
  input  logic       rst,                   // asynchronous, active-low
  wb_stage_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(LOAD_TIMEOUT);

  // Writeback value mux: 01 selects load data, 10 the link address, else ALU.
  function automatic logic [31:0] wb_mux(
    input logic [1:0]  src,
    input logic [31:0] alu,
    input logic [31:0] mdata,
    input logic [31:0] pc4
  );
    logic [31:0] r;
    case (src)
      2'b00:   r = alu;
      2'b01:   r = mdata;
      2'b10:   r = pc4;
      2'b11:   r = alu;
      default: r = alu;
    endcase
    return r;
  endfunction

  logic        rf_wb_s;
  logic [1:0]  wb_src_s;
  logic        pc_src_s;
  logic [4:0]  rd_s;
  logic        is_load_s;
  logic        stall_s;
  logic        accept_s;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        load_err_q, load_err_d;
  logic        wb_valid_q, wb_valid_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        pc_redirect_q, pc_redirect_d;
  logic [31:0] pc_redirect_target_q, pc_redirect_target_d;

  // Decode the control word and derive stall/accept; flush overrides everything.
  always_comb begin
    rf_wb_s   = bus.control_word_mem[8];
    wb_src_s  = bus.control_word_mem[7:6];
    pc_src_s  = bus.control_word_mem[5];
    rd_s      = bus.control_word_mem[4:0];
    is_load_s = bus.valid_mem & (wb_src_s == 2'b01);
    stall_s   = is_load_s & ~bus.mem_rdy & ~bus.flush;
    accept_s  = bus.valid_mem & ~bus.flush & ~(is_load_s & ~bus.mem_rdy);
  end

  // Load-wait FSM next state, wait counter (0 whenever IDLE) and sticky timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = 8'd0;
    load_err_d = load_err_q;
    case (state_q)
      IDLE: begin
        if (stall_s) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (bus.mem_rdy | bus.flush) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == WAIT) begin
      cnt_d = (cnt_q == 8'd255) ? 8'd255 : cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
    if (cnt_d >= TIMEOUT_C) begin
      load_err_d = 1'b1;
    end else begin
      load_err_d = load_err_q;
    end
  end

  // Writeback register next values: load on accept, otherwise bubble and hold data.
  always_comb begin
    wb_valid_d           = 1'b0;
    rf_we_d              = 1'b0;
    pc_redirect_d        = 1'b0;
    rf_waddr_d           = rf_waddr_q;
    rf_wdata_d           = rf_wdata_q;
    pc_redirect_target_d = pc_redirect_target_q;
    if (accept_s) begin
      wb_valid_d           = 1'b1;
      rf_we_d              = rf_wb_s & (rd_s != 5'd0);
      rf_waddr_d           = rd_s;
      rf_wdata_d           = wb_mux(wb_src_s, bus.ALU_result_mem,
                                    bus.memory_stage_data, bus.pc_plus4_mem);
      pc_redirect_d        = pc_src_s;
      pc_redirect_target_d = bus.target_pc;
    end else begin
      wb_valid_d           = 1'b0;
      rf_we_d              = 1'b0;
      pc_redirect_d        = 1'b0;
    end
  end

  // State, counter, error flag and writeback registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q              <= IDLE;
      cnt_q                <= 8'd0;
      load_err_q           <= 1'b0;
      wb_valid_q           <= 1'b0;
      rf_we_q              <= 1'b0;
      rf_waddr_q           <= 5'd0;
      rf_wdata_q           <= 32'd0;
      pc_redirect_q        <= 1'b0;
      pc_redirect_target_q <= 32'd0;
    end else begin
      state_q              <= state_d;
      cnt_q                <= cnt_d;
      load_err_q           <= load_err_d;
      wb_valid_q           <= wb_valid_d;
      rf_we_q              <= rf_we_d;
      rf_waddr_q           <= rf_waddr_d;
      rf_wdata_q           <= rf_wdata_d;
      pc_redirect_q        <= pc_redirect_d;
      pc_redirect_target_q <= pc_redirect_target_d;
    end
  end

`ifdef WB_INSTRET_EN
  logic [31:0] instret_q, instret_d;

  // Retired-instruction count; wraps naturally at 32 bits.
  always_comb begin
    if (accept_s) begin
      instret_d = instret_q + 32'd1;
    end else begin
      instret_d = instret_q;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= 32'd0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign bus.instret = instret_q;
`else
  assign bus.instret = 32'd0;
`endif

  assign bus.stall_mem          = stall_s;
  assign bus.wb_valid           = wb_valid_q;
  assign bus.rf_we              = rf_we_q;
  assign bus.rf_waddr           = rf_waddr_q;
  assign bus.rf_wdata           = rf_wdata_q;
  assign bus.pc_redirect        = pc_redirect_q;
  assign bus.pc_redirect_target = pc_redirect_target_q;
  assign bus.load_err           = load_err_q;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter LOAD_TIMEOUT, default 8, max consecutive load-wait cycles before load_err sets (range 1..255).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 control_word_mem  input  9  {rf_wb, wb_src[1:0], pc_src, rd[4:0]} from memory stage.
REQ-005 ALU_result_mem  input  32  ALU result passed through memory stage.
REQ-006 memory_stage_data  input  32  load data, already extended and aligned.
REQ-007 pc_plus4_mem  input  32  PC+4 of the instruction in memory stage.
REQ-008 target_pc  input  32  branch/jump target from memory stage.
REQ-009 valid_mem  input  1  memory-stage slot holds a real instruction.
REQ-010 mem_rdy  input  1  load data on memory_stage_data is valid this cycle.
REQ-011 flush  input  1  kill the memory-stage instruction.
REQ-012 stall_mem  output  1  hold memory stage and all upstream stages.
REQ-013 rf_we, rf_waddr[4:0], rf_wdata[31:0]  output  register-file write port.
REQ-014 pc_redirect, pc_redirect_target[31:0]  output  one-cycle fetch redirect.
REQ-015 wb_valid  output  1  the writeback register holds a retired instruction.
REQ-016 load_err  output  1  sticky load-timeout flag.
REQ-017 instret  output  32  retired-instruction count (see Configuration).

Function
REQ-018 is_load SHALL be defined as valid_mem & (wb_src==2'b01); accept SHALL be defined as valid_mem & ~flush & ~(is_load & ~mem_rdy).
REQ-019 The FSM SHALL have two states: IDLE and WAIT; IDLE->WAIT when is_load & ~mem_rdy & ~flush; WAIT->IDLE when mem_rdy or flush.
REQ-020 stall_mem SHALL be combinational: is_load & ~mem_rdy & ~flush, in either state.
REQ-021 The wait counter SHALL be 8 bits, cleared in IDLE, incremented each WAIT cycle, saturating at 255; load_err SHALL set when the counter reaches LOAD_TIMEOUT and stay set until reset.
REQ-022 Writeback registers SHALL capture on every rising edge; latency is exactly 1 cycle from the accepting edge.
REQ-023 When accept=1, the registers SHALL load wb_valid=1, rf_waddr=rd, rf_we=rf_wb & (rd!=0), and rf_wdata per wb_src: 00 ALU_result_mem, 01 memory_stage_data, 10 pc_plus4_mem, 11 ALU_result_mem.
REQ-024 When accept=1, the registers SHALL load pc_redirect=pc_src and pc_redirect_target=target_pc.
REQ-025 When accept=0 (bubble, flush or stalled load), the registers SHALL load wb_valid=0, rf_we=0 and pc_redirect=0; rf_waddr, rf_wdata and pc_redirect_target SHALL hold their previous values.
REQ-026 flush SHALL take priority over mem_rdy and stall; a flush in WAIT SHALL return to IDLE, clear the counter and drop stall_mem in the same cycle.
REQ-027 A write to rd=0 SHALL never assert rf_we, but it SHALL still count as retired and still redirect if pc_src=1.
REQ-028 A load with mem_rdy=1 on its first cycle SHALL incur no stall and SHALL stay in IDLE.

Reset
REQ-029 While rst=0, the block SHALL be in state IDLE with the counter at 0.
REQ-030 While rst=0, wb_valid, rf_we, pc_redirect and load_err SHALL be 0.
REQ-031 While rst=0, rf_waddr, rf_wdata, pc_redirect_target and instret SHALL be 0.
REQ-032 Reset asserted mid-WAIT SHALL abort the load immediately; stall_mem then follows only its combinational inputs.

Configuration
REQ-033 With macro WB_INSTRET_EN defined, instret SHALL be a 32-bit counter that increments by 1 on each edge where accept=1 and that wraps from 0xFFFFFFFF to 0.
REQ-034 Without WB_INSTRET_EN, instret SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-035 ALU op: rf_wb=1, wb_src=00, rd=5, ALU_result_mem=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, wb_valid=1.
REQ-036 Load with mem_rdy low for 3 cycles, then data 0xDEADBEEF -> stall_mem=1 for 3 cycles, then rf_wdata=0xDEADBEEF with exactly one rf_we pulse.
REQ-037 JAL: rd=1, wb_src=10, pc_src=1, pc_plus4_mem=0x104, target_pc=0x200 -> rf_wdata=0x104, pc_redirect=1 for 1 cycle, target 0x200.
REQ-038 Load stalled 8 cycles with LOAD_TIMEOUT=8 -> load_err=1 and stays set; then flush -> stall_mem=0 immediately and next cycle wb_valid=0.
REQ-039 rd=0 with rf_wb=1 -> rf_we=0, wb_valid=1; with WB_INSTRET_EN, instret preset to 0xFFFFFFFF -> 0 after one accepted instruction.
